// File: rtl/lathe_seq_pkg.sv
// Shared encodings for the lathe cycle sequencer: FSM states and the
// bit layout of the registered relay drive word.
package lathe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPINUP  = 3'd1,
    RUN     = 3'd2,
    RUNDOWN = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int OUT_SPINDLE   = 0;
  localparam int OUT_COOLANT   = 1;
  localparam int OUT_FEED      = 2;
  localparam int OUT_BUSY      = 3;
  localparam int OUT_FAULT     = 4;
  localparam int OUT_STATE_LSB = 5;
  localparam int OUT_W         = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// On-delay counter shared by the spin-up and run-down phases; done is
// asserted while the count sits at preset-1.
module seq_delay_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         count_en,
  input  logic [W-1:0] preset,
  output logic         done
);

  logic [W-1:0] count_q;

  // Clear wins over counting so every phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign done = (count_q == (preset - W'(1)));

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Spindle/coolant/feed sequencer with e-stop/guard interlock and
// AUTO/MAN mode rules; all drive outputs come straight from flops.
module lathe_cycle_sequencer
  import lathe_seq_pkg::*;
#(
  parameter int SPINUP_CYC  = 20,
  parameter int RUNDOWN_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       auto_i,
  input  logic       man_i,
  input  logic       feed_req_i,
  input  logic       estop_n_i,
  input  logic       guard_closed_i,
  input  logic       fault_clr_i,
  output logic       spindle_en_o,
  output logic       coolant_en_o,
  output logic       feed_en_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(max_int(SPINUP_CYC, RUNDOWN_CYC) + 1);

  state_t             state_q, state_d;
  logic               start_q, stop_q;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               ok, mode_valid, start_rise, stop_rise;
  logic               timer_clear, timer_en, timer_done;
  logic [CW-1:0]      timer_preset;

  assign ok         = estop_n_i & guard_closed_i;
  assign mode_valid = auto_i ^ man_i;
  assign start_rise = start_i & ~start_q;
  assign stop_rise  = stop_i & ~stop_q;

  // One timer serves both timed phases; preset follows the current state.
  assign timer_preset = (state_q == SPINUP) ? CW'(SPINUP_CYC) : CW'(RUNDOWN_CYC);
  assign timer_clear  = ena && (state_d != state_q);
  assign timer_en     = ena && ((state_q == SPINUP) || (state_q == RUNDOWN));

  seq_delay_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .count_en (timer_en),
    .preset   (timer_preset),
    .done     (timer_done)
  );

  // Branch order encodes priority: interlock, then stop/mode loss, then expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise && ok && mode_valid) state_d = SPINUP;
      end
      SPINUP: begin
        if (!ok)                           state_d = FAULT;
        else if (stop_rise || !mode_valid) state_d = RUNDOWN;
        else if (timer_done)               state_d = RUN;
      end
      RUN: begin
        if (!ok)                           state_d = FAULT;
        else if (stop_rise || !mode_valid) state_d = RUNDOWN;
      end
      RUNDOWN: begin
        if (!ok)             state_d = FAULT;
        else if (timer_done) state_d = IDLE;
      end
      FAULT: begin
        if (fault_clr_i && ok && !start_i) state_d = RUNDOWN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive word is decoded from the next state so it updates with the state.
  always_comb begin
    out_d = '0;
    out_d[OUT_STATE_LSB +: 3] = state_d;
    out_d[OUT_BUSY]           = (state_d != IDLE);
    out_d[OUT_FAULT]          = (state_d == FAULT);
    case (state_d)
      SPINUP: begin
        out_d[OUT_SPINDLE] = 1'b1;
        out_d[OUT_COOLANT] = 1'b1;
      end
      RUN: begin
        out_d[OUT_SPINDLE] = 1'b1;
        out_d[OUT_COOLANT] = 1'b1;
        out_d[OUT_FEED]    = auto_i ? 1'b1 : feed_req_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      out_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      start_q <= start_i;
      stop_q  <= stop_i;
      out_q   <= out_d;
    end
  end

  assign spindle_en_o = out_q[OUT_SPINDLE];
  assign coolant_en_o = out_q[OUT_COOLANT];
  assign feed_en_o    = out_q[OUT_FEED];
  assign busy_o       = out_q[OUT_BUSY];
  assign fault_o      = out_q[OUT_FAULT];
  assign state_o      = out_q[OUT_STATE_LSB +: 3];

endmodule
